vec_alu_seq: RTL and testbench

- Multi-lane sequential vector ALU; successor to the single-element ALU.
- Executes one vector operation over VLEN elements of N bits, using LANES element ALUs per clock, so each operation takes VLEN/LANES beats.
- Sits between the vector register file read stage and writeback.
- valid/ready handshake on input and output; result and flags held until consumed.

---
 rtl/vec_alu_seq.sv | 177 +++++++++++++++++
 tb/tb_vec_alu_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_seq.sv
// Multi-lane sequential vector ALU: latches one vector operation, computes LANES
// elements per beat over VLEN/LANES beats, and holds result and flags until consumed.
module vec_alu_seq #(
  parameter int N     = 8,
  parameter int VLEN  = 4,
  parameter int LANES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [VLEN*N-1:0] vec_a,
  input  logic [VLEN*N-1:0] vec_b,
  input  logic [N-1:0]      scalar,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VLEN*N-1:0] result,
  output logic [3:0]        flags,
  output logic              illegal_op
);

  localparam int BEATS = VLEN / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(N);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [3:0]        op_q, op_d;
  logic [VLEN*N-1:0] a_q, a_d;
  logic [VLEN*N-1:0] b_q, b_d;
  logic [N-1:0]      scalar_q, scalar_d;
  logic [VLEN*N-1:0] result_q, result_d;
  logic [3:0]        flags_q, flags_d;
  logic              illegal_q, illegal_d;

  logic [N-1:0]   ea, eb, bx, bxp, res_e;
  logic [N:0]     sum;
  logic [2*N-1:0] rot_tmp;
  logic [AW-1:0]  amt;
  logic           is_sub, is_arith;
  logic           n_acc, z_acc, c_acc, v_acc;
  int             idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      scalar_q  <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      scalar_q  <= scalar_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  // Per-beat lane datapath: results and partial flags for the current slice of elements.
  always_comb begin
    result_d = result_q;
    n_acc    = 1'b0;
    z_acc    = 1'b1;
    c_acc    = 1'b0;
    v_acc    = 1'b0;
    ea       = '0;
    eb       = '0;
    bx       = '0;
    bxp      = '0;
    res_e    = '0;
    sum      = '0;
    rot_tmp  = '0;
    idx      = 0;
    amt      = scalar_q[AW-1:0];
    is_sub   = (op_q[3:1] == 3'b110);
    is_arith = (op_q[3:1] == 3'b101) || is_sub;
    for (int l = 0; l < LANES; l++) begin
      idx   = int'(beat_q) * LANES + l;
      ea    = a_q[idx*N +: N];
      eb    = b_q[idx*N +: N];
      bx    = op_q[0] ^ op_q[3] ? eb : scalar_q;
      bxp   = is_sub ? ~bx : bx;
      sum   = {1'b0, ea} + {1'b0, bxp} + {{N{1'b0}}, is_sub};
      res_e = '0;
      rot_tmp = '0;
      case (op_q)
        4'b0000, 4'b0001: res_e = ea & bx;
        4'b0010, 4'b0011: res_e = ea | bx;
        4'b0100, 4'b0101: res_e = ea ^ bx;
        4'b0110:          res_e = ea >> amt;
        4'b0111:          res_e = ea << amt;
        4'b1000: begin
          rot_tmp = {ea, ea} >> amt;
          res_e   = rot_tmp[N-1:0];
        end
        4'b1001: begin
          rot_tmp = {ea, ea} << amt;
          res_e   = rot_tmp[2*N-1:N];
        end
        4'b1010, 4'b1011, 4'b1100, 4'b1101: res_e = sum[N-1:0];
        default:          res_e = '0;
      endcase
      result_d[idx*N +: N] = res_e;
      n_acc = n_acc | res_e[N-1];
      z_acc = z_acc & (res_e == '0);
      if (is_arith) begin
        c_acc = c_acc | sum[N];
        v_acc = v_acc | ((ea[N-1] == bxp[N-1]) && (sum[N-1] != ea[N-1]));
      end
    end
  end

  // Control FSM; flags start at {N=0,Z=1,C=0,V=0} on accept and fold in each beat.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    scalar_d  = scalar_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d      = op;
          a_d       = vec_a;
          b_d       = vec_b;
          scalar_d  = scalar;
          beat_d    = '0;
          flags_d   = 4'b0100;
          illegal_d = (op[3:1] == 3'b111);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        flags_d = {flags_q[3] | n_acc, flags_q[2] & z_acc,
                   flags_q[1] | c_acc, flags_q[0] | v_acc};
        if (beat_q == BW'(BEATS - 1)) begin
          beat_d  = '0;
          state_d = DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [VLEN*N-1:0] result_next;
  always_comb begin
    result_next = result_q;
    if (state_q == EXEC) result_next = result_d;
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign result     = result_q;
  assign flags      = flags_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Scoreboard testbench for vec_alu_seq (N=8, VLEN=4, LANES=2): directed vectors with
// hand-computed results, latency, backpressure, illegal opcode and async reset checks.
module tb_vec_alu_seq;

  localparam int N     = 8;
  localparam int VLEN  = 4;
  localparam int LANES = 2;
  localparam int BEATS = VLEN / LANES;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] vec_a;
  logic [31:0] vec_b;
  logic [7:0]  scalar;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        illegal_op;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  vec_alu_seq #(.N(N), .VLEN(VLEN), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .vec_a(vec_a), .vec_b(vec_b), .scalar(scalar),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  // Monitor: compares against the scoreboard whenever a result is handed over.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("result", result, mon_e.res);
        checkOutput("flags", {28'd0, flags}, {28'd0, mon_e.flg});
        checkOutput("illegal_op", {31'd0, illegal_op}, {31'd0, mon_e.ill});
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic scramble();
    op     = 4'($urandom_range(15));
    vec_a  = $urandom;
    vec_b  = $urandom;
    scalar = 8'($urandom);
  endtask

  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [7:0] s, input logic [31:0] er, input logic [3:0] ef,
                               input logic ei, input bit hold);
    waitIdle();
    op = o; vec_a = a; vec_b = b; scalar = s;
    in_valid  = 1'b1;
    out_ready = !hold;
    sb.push_back('{er, ef, ei});
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    checkOutput("in_ready_exec", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < BEATS; k++) begin
      checkOutput("no_early_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    checkOutput("valid_latency", {31'd0, out_valid}, 32'd1);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        in_valid = 1'($urandom);
        scramble();
        @(posedge clk); #1;
        checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("hold_result", result, er);
        checkOutput("hold_flags", {28'd0, flags}, {28'd0, ef});
        checkOutput("hold_illegal", {31'd0, illegal_op}, {31'd0, ei});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("release_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      checkOutput("no_second_accept", {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; vec_a = '0; vec_b = '0; scalar = '0;
    #2;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_flags", {28'd0, flags}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(4'b0000, pk(8'hF0, 8'h0F, 8'hAA, 8'h55), 32'hDEADBEEF, 8'h3C,
                  pk(8'h30, 8'h0C, 8'h28, 8'h14), 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1010, pk(8'h7F, 8'h01, 8'hFF, 8'h00), pk(8'h01, 8'h01, 8'h01, 8'h00), 8'hA5,
                  pk(8'h80, 8'h02, 8'h00, 8'h00), 4'b1011, 1'b0, 1'b0);
    applyStimulus(4'b1101, pk(8'h05, 8'h00, 8'h80, 8'h03), 32'h12345678, 8'h03,
                  pk(8'h02, 8'hFD, 8'h7D, 8'h00), 4'b1011, 1'b0, 1'b0);
    applyStimulus(4'b1001, pk(8'h81, 8'h01, 8'h80, 8'h00), 32'hCAFEF00D, 8'h09,
                  pk(8'h03, 8'h02, 8'h01, 8'h00), 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0111, pk(8'h81, 8'h01, 8'h80, 8'h00), 32'hCAFEF00D, 8'h09,
                  pk(8'h02, 8'h02, 8'h00, 8'h00), 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0101, pk(8'hFF, 8'h00, 8'h12, 8'h34), pk(8'h0F, 8'h00, 8'h12, 8'hF0), 8'h77,
                  pk(8'hF0, 8'h00, 8'h00, 8'hC4), 4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b0110, pk(8'h80, 8'hFF, 8'h01, 8'h10), 32'h0, 8'h0B,
                  pk(8'h10, 8'h1F, 8'h00, 8'h02), 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1000, pk(8'h01, 8'h80, 8'h03, 8'h00), 32'hFFFFFFFF, 8'h00,
                  pk(8'h01, 8'h80, 8'h03, 8'h00), 4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b1000, pk(8'h01, 8'h02, 8'h03, 8'h00), 32'h0, 8'h01,
                  pk(8'h80, 8'h01, 8'h81, 8'h00), 4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b0011, pk(8'h01, 8'h02, 8'h00, 8'h00), pk(8'h10, 8'h20, 8'h00, 8'h00), 8'hFF,
                  pk(8'h11, 8'h22, 8'h00, 8'h00), 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1100, pk(8'h10, 8'h20, 8'h30, 8'h40), pk(8'h10, 8'h20, 8'h30, 8'h40), 8'h00,
                  32'h0, 4'b0110, 1'b0, 1'b0);
    applyStimulus(4'b1011, pk(8'hFF, 8'hFE, 8'h00, 8'h7E), 32'h55AA55AA, 8'h01,
                  pk(8'h00, 8'hFF, 8'h01, 8'h7F), 4'b1010, 1'b0, 1'b0);
    applyStimulus(4'b1010, pk(8'h7F, 8'h01, 8'hFF, 8'h00), pk(8'h01, 8'h01, 8'h01, 8'h00), 8'h00,
                  pk(8'h80, 8'h02, 8'h00, 8'h00), 4'b1011, 1'b0, 1'b1);
    applyStimulus(4'b1110, 32'h89ABCDEF, 32'h13579BDF, 8'h5A,
                  32'h0, 4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b0001, pk(8'hF0, 8'h3C, 8'hFF, 8'h81), pk(8'h0F, 8'h0F, 8'h81, 8'h01), 8'h00,
                  pk(8'h00, 8'h0C, 8'h81, 8'h01), 4'b1000, 1'b0, 1'b0);

    // Reset mid-EXEC: the in-flight operation must vanish without a clock edge.
    waitIdle();
    op = 4'b1010; vec_a = 32'h01020304; vec_b = 32'h01010101; scalar = 8'h00;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_rst_result", result, 32'd0);
    checkOutput("async_rst_flags", {28'd0, flags}, 32'd0);
    checkOutput("async_rst_illegal", {31'd0, illegal_op}, 32'd0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    end

    applyStimulus(4'b0100, pk(8'hAA, 8'h55, 8'h00, 8'hFF), 32'h0, 8'hFF,
                  pk(8'h55, 8'hAA, 8'hFF, 8'h00), 4'b1000, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
